te_bm_sched: RTL



---
 rtl/te_bm_pkg.sv | 14 +
 rtl/te_bm_rr_pick.sv | 30 +++
 rtl/te_bm_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/te_bm_pkg.sv
// Shared types and default configuration for the buffer-memory access scheduler.
package te_bm_pkg;

  localparam int unsigned N_RR_DEF         = 5;
  localparam int unsigned WEIGHT_W_DEF     = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    TC_BURST,
    RR_BURST
  } bm_state_e;

endpackage

// File: rtl/te_bm_rr_pick.sv
// Rotating one-hot picker: searches ptr+1, ptr+2, ... wrapping, ptr itself last.
module te_bm_rr_pick #(
  parameter int unsigned N  = 5,
  parameter int unsigned PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = PW'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/te_bm_sched.sv
// BM arbiter: TC has priority, weighted round-robin among the remaining requesters.
// Optional starvation guard enabled by defining TE_BM_SCHED_STARVE_EN.
module te_bm_sched
  import te_bm_pkg::*;
#(
  parameter int unsigned N_RR         = N_RR_DEF,
  parameter int unsigned WEIGHT_W     = WEIGHT_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_RR-1:0]            rr_req,
  input  logic [N_RR-1:0]            rr_last,
  input  logic [N_RR*WEIGHT_W-1:0]   rr_weight,
  input  logic                       tc_req,
  input  logic                       tc_last,
  output logic [N_RR-1:0]            gnt_rr,
  output logic                       gnt_tc,
  output logic                       busy,
  output logic                       starve_evt
);

  localparam int unsigned PW = (N_RR > 1) ? $clog2(N_RR) : 1;

  bm_state_e            state_q, state_d;
  logic [N_RR-1:0]      gnt_rr_q, gnt_rr_d;
  logic                 gnt_tc_q, gnt_tc_d;
  logic                 busy_q;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  logic [N_RR-1:0]      pick_oh, hold_oh;
  logic [PW-1:0]        pick_idx;
  logic                 rr_any;
  logic [WEIGHT_W-1:0]  pick_w;
  logic                 decide, starve_force, tc_win, rr_win;

  te_bm_rr_pick #(.N(N_RR), .PW(PW)) u_pick (
    .req_i   (rr_req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (rr_any)
  );

  always_comb begin
    pick_w  = '0;
    hold_oh = '0;
    for (int unsigned i = 0; i < N_RR; i++) begin
      if (pick_oh[i]) pick_w = rr_weight[i*WEIGHT_W +: WEIGHT_W];
      hold_oh[i] = (ptr_q == PW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_rr_d = gnt_rr_q;
    gnt_tc_d = gnt_tc_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    tc_win   = 1'b0;
    rr_win   = 1'b0;
    decide   = 1'b0;
    case (state_q)
      TC_BURST: decide = tc_req & tc_last;
      RR_BURST: decide = rr_req[ptr_q] & rr_last[ptr_q];
      default:  decide = 1'b1;
    endcase
    if (decide) begin
      if (tc_req && !(starve_force && rr_any)) begin
        state_d  = TC_BURST;
        gnt_tc_d = 1'b1;
        gnt_rr_d = '0;
        tc_win   = 1'b1;
      end else if (rr_any) begin
        state_d  = RR_BURST;
        gnt_tc_d = 1'b0;
        rr_win   = 1'b1;
        // Previous owner keeps its turn while credit remains; otherwise rotate.
        if (rr_req[ptr_q] && credit_q != '0) begin
          gnt_rr_d = hold_oh;
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          gnt_rr_d = pick_oh;
          ptr_d    = pick_idx;
          credit_d = (pick_w == '0) ? '0 : pick_w - WEIGHT_W'(1);
        end
      end else begin
        state_d  = IDLE;
        gnt_rr_d = '0;
        gnt_tc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_rr_q <= '0;
      gnt_tc_q <= 1'b0;
      busy_q   <= 1'b0;
      ptr_q    <= PW'(N_RR - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_rr_q <= gnt_rr_d;
      gnt_tc_q <= gnt_tc_d;
      busy_q   <= (state_d != IDLE);
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

`ifdef TE_BM_SCHED_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_evt_q, starve_evt_d;

  assign starve_force = (starve_cnt_q >= CW'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    starve_evt_d = rr_win & starve_force & tc_req;
    if (!rr_any || rr_win) starve_cnt_d = '0;
    else if (tc_win && !starve_force) starve_cnt_d = starve_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      starve_evt_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_evt_q <= starve_evt_d;
    end
  end

  assign starve_evt = starve_evt_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign starve_force        = 1'b0;
  assign starve_evt          = 1'b0;
`endif

  assign gnt_rr = gnt_rr_q;
  assign gnt_tc = gnt_tc_q;
  assign busy   = busy_q;

endmodule
